mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port MDOp, input, 3 bits: E-stage operation; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-004 SHALL have port A, input, 32 bits: rs operand (dividend, multiplicand, or mthi/mtlo source).
REQ-005 SHALL have port B, input, 32 bits: rt operand (divisor, multiplier).
REQ-006 SHALL have port Req, input, 1 bit: exception/interrupt taken this cycle; the E-stage operation is cancelled.
REQ-007 SHALL have port Start, output, 1 bit: combinational; a mult/div is accepted this cycle.
REQ-008 SHALL have port Busy, output, 1 bit: registered; a mult/div is in progress.
REQ-009 SHALL have port HI, output, 32 bits: registered HI value.
REQ-010 SHALL have port LO, output, 32 bits: registered LO value.

Function
REQ-011 Start SHALL equal (MDOp in 1..4) AND NOT Req AND NOT Busy.
REQ-012 On an edge with Start=1, A, B and MDOp SHALL be latched, counter loaded (5 for mult/multu, 10 for div/divu), Busy set to 1.
REQ-013 States: IDLE (Busy=0) and RUN (Busy=1); IDLE->RUN on Start; RUN decrements counter each edge; RUN->IDLE on the edge where counter goes 1->0.
REQ-014 Busy SHALL be high for exactly 5 (mult) or 10 (div) cycles after the Start cycle; HI/LO SHALL update on the same edge that clears Busy.
REQ-015 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-016 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-017 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-018 mthi/mtlo SHALL write A into HI/LO on the edge when NOT Req AND NOT Busy; no latency, Busy unaffected.
REQ-019 Any MDOp arriving while Busy=1 SHALL be ignored (no Start, no mthi/mtlo write); stall logic upstream prevents it.
REQ-020 Req=1 while Busy=1 SHALL NOT cancel the running operation; it completes and writes HI/LO.
REQ-021 Req=1 with MDOp in 1..6 and Busy=0 SHALL produce no state change.
REQ-022 HI/LO SHALL hold their value at all other times; operand inputs changing during RUN SHALL NOT affect the result.

Reset
REQ-023 With reset=1 at an edge: HI=0, LO=0, Busy=0, counter=0, latched operands cleared; overrides Start and mthi/mtlo that cycle.
REQ-024 Reset during RUN SHALL abort the operation with no HI/LO write; Start may assert in the first cycle after reset deasserts.

Configuration
REQ-025 Macro MDU_DIVZERO_HOLD_EN: when defined, div/divu with B=0 SHALL complete normal 10-cycle Busy timing but leave HI/LO unchanged.
REQ-026 When MDU_DIVZERO_HOLD_EN is undefined, div/divu with B=0 SHALL write LO=0xFFFFFFFF, HI=A (no X propagation).

Verification
REQ-027 mult A=0xFFFFFFFE (-2), B=3 -> Start=1 cycle T, Busy=1 T+1..T+5, from T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 multu A=0xFFFFFFFF, B=2 -> from T+6 HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 div A=-7, B=2 -> Busy T+1..T+10, from T+11 LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-030 mtlo A=0x12345678 with Req=1 -> LO unchanged; repeat with Req=0 -> LO=0x12345678 next cycle, Busy stays 0.
REQ-031 Start mult, assert reset at T+3 -> Busy=0, HI=LO=0 after edge, no later update.
REQ-032 divu A=9, B=0 -> with MDU_DIVZERO_HOLD_EN HI/LO unchanged; without it LO=0xFFFFFFFF, HI=9, both after 10 Busy cycles.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if -- E-stage operation/result bundle of the multiply/divide
// unit.
//   MDOp  [2:0]  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mthi, 6 mtlo, 7 reserved (acts as none)
//   A    [31:0]  rs operand (dividend / multiplicand / mthi-mtlo source)
//   B    [31:0]  rt operand (divisor / multiplier)
//   Req          exception/interrupt taken; cancels the E-stage operation
//   Start        combinational: a mult/div is accepted this cycle
//   Busy         registered: a mult/div is in progress
//   HI, LO[31:0] registered HI/LO values
// master = pipeline side, slave = the unit.
// ---------------------------------------------------------------------------
interface mult_div_unit_if;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDOp, A, B, Req,
    input  Start, Busy, HI, LO
  );

  modport slave (
    input  MDOp, A, B, Req,
    output Start, Busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit -- multi-cycle multiply/divide unit with HI/LO registers.
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   md     mult_div_unit_if.slave (MDOp, A, B, Req in; Start, Busy, HI, LO out)
// A mult/multu occupies the unit for 5 cycles, div/divu for 10. Operands are
// captured when the operation is accepted; the result is computed from the
// captured copies and written to HI/LO on the edge that drops Busy.
// mthi/mtlo write HI/LO immediately when the unit is idle and not cancelled.
//
// Configuration macro: MDU_DIVZERO_HOLD_EN
//   defined   - div/divu by zero keeps the normal timing, HI/LO unchanged
//   undefined - div/divu by zero writes LO=0xFFFFFFFF, HI=dividend
// ---------------------------------------------------------------------------
module mult_div_unit (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  state_e      state;
  logic [3:0]  count;
  md_op_e      op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  md_op_e      in_op;
  logic        in_is_md;
  logic        in_is_div;

  assign in_op     = md_op_e'(md.MDOp);
  assign in_is_md  = (in_op == OP_MULT) || (in_op == OP_MULTU) ||
                     (in_op == OP_DIV)  || (in_op == OP_DIVU);
  assign in_is_div = (in_op == OP_DIV)  || (in_op == OP_DIVU);

  assign md.Start = in_is_md && !md.Req && (state == ST_IDLE);
  assign md.Busy  = (state == ST_RUN);
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

  // -------------------------------------------------------------------------
  // Result datapath, driven only by the captured operands so that operand
  // inputs may change freely while the unit runs.
  // -------------------------------------------------------------------------
  logic        res_signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic        div_zero;
  logic        res_write;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    res_signed_div = (op_code == OP_DIV);
    a_neg          = res_signed_div && op_a[31];
    b_neg          = res_signed_div && op_b[31];
    a_mag          = a_neg ? (32'd0 - op_a) : op_a;
    b_mag          = b_neg ? (32'd0 - op_b) : op_b;
    dvd            = a_mag;
    dvs            = b_mag;
    div_zero       = (op_b == 32'd0);
    // Divide by a harmless 1 on zero so the datapath never produces X; the
    // zero case is resolved by the select below.
    dvs_safe       = div_zero ? 32'd1 : dvs;
    // Magnitude division: 0x80000000 / 0xFFFFFFFF becomes 0x80000000 / 1 with
    // equal signs, yielding the required 0x80000000 remainder 0.
    q_mag          = dvd / dvs_safe;
    r_mag          = dvd % dvs_safe;
    prod_u         = {32'd0, op_a} * {32'd0, op_b};
    prod_s         = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    res_hi         = hi_q;
    res_lo         = lo_q;
    res_write      = 1'b1;

    case (op_code)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (div_zero) begin
`ifdef MDU_DIVZERO_HOLD_EN
          res_write = 1'b0;
`else
          res_lo    = 32'hFFFF_FFFF;
          res_hi    = op_a;
`endif
        end else begin
          res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
          res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
        end
      end
      default:  res_write = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM and HI/LO registers.
  // -------------------------------------------------------------------------
  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= 4'd0;
      op_code <= OP_NONE;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.Start) begin
            state   <= ST_RUN;
            count   <= in_is_div ? DIV_CYCLES : MULT_CYCLES;
            op_code <= in_op;
            op_a    <= md.A;
            op_b    <= md.B;
          end else if (!md.Req) begin
            if (in_op == OP_MTHI) hi_q <= md.A;
            if (in_op == OP_MTLO) lo_q <= md.A;
          end
        end
        ST_RUN: begin
          // Req and new MDOp values are deliberately ignored while running.
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= ST_IDLE;
            if (res_write) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
